// File: rtl/ex_div_seq.sv
// EX-stage divide sequencer: radix-2 restoring DIV/DIVU, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN finishes in one cycle when |dividend| < |divisor|.
module ex_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               div_start,
    input  logic               div_signed,
    input  logic [WIDTH-1:0]   div_opdata1,
    input  logic [WIDTH-1:0]   div_opdata2,
    input  logic               div_annul,
    output logic [2*WIDTH-1:0] div_result,
    output logic               div_ready,
    output logic               div_stall_req
);

    localparam int unsigned RES_W = 2 * WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               ready_q, ready_d;

    // Operand magnitudes as seen at the start edge
    logic               op1_neg_c;
    logic               op2_neg_c;
    logic [WIDTH-1:0]   op1_mag_c;
    logic [WIDTH-1:0]   op2_mag_c;

    // One restoring iteration on the current partial remainder / dividend
    logic [WIDTH:0]     shift_rem_c;
    logic [WIDTH:0]     diff_c;
    logic               take_c;
    logic [WIDTH-1:0]   rem_next_c;
    logic [WIDTH-1:0]   dvd_next_c;
    logic [WIDTH-1:0]   quot_fix_c;
    logic [WIDTH-1:0]   rem_fix_c;

    always_comb begin
        op1_neg_c = div_signed & div_opdata1[WIDTH-1];
        op2_neg_c = div_signed & div_opdata2[WIDTH-1];
        op1_mag_c = op1_neg_c ? (~div_opdata1 + WIDTH'(1)) : div_opdata1;
        op2_mag_c = op2_neg_c ? (~div_opdata2 + WIDTH'(1)) : div_opdata2;
    end

    // A clear borrow bit means the shifted remainder covers the divisor
    always_comb begin
        shift_rem_c = {rem_q, dvd_q[WIDTH-1]};
        diff_c      = shift_rem_c - {1'b0, dvs_q};
        take_c      = ~diff_c[WIDTH];
        rem_next_c  = take_c ? diff_c[WIDTH-1:0] : shift_rem_c[WIDTH-1:0];
        dvd_next_c  = (dvd_q << 1) | WIDTH'(take_c);
        quot_fix_c  = q_neg_q ? (~dvd_next_c + WIDTH'(1)) : dvd_next_c;
        rem_fix_c   = r_neg_q ? (~rem_next_c + WIDTH'(1)) : rem_next_c;
    end

    // Next-state and result logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        ready_d  = ready_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b0;
                if (div_start) begin
                    q_neg_d = op1_neg_c ^ op2_neg_c;
                    r_neg_d = op1_neg_c;
                    dvd_d   = op1_mag_c;
                    dvs_d   = op2_mag_c;
                    rem_d   = '0;
                    cnt_d   = '0;
                    if (div_opdata2 == '0) begin
                        state_d = S_BYZERO;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (op1_mag_c < op2_mag_c) begin
                        state_d  = S_END;
                        result_d = {div_opdata1, WIDTH'(0)};
                        ready_d  = 1'b1;
                    end
`endif
                    else begin
                        state_d = S_ON;
                    end
                end
            end

            S_ON: begin
                rem_d = rem_next_c;
                dvd_d = dvd_next_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d = {rem_fix_c, quot_fix_c};
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end
            end

            S_BYZERO: begin
                result_d = '0;
                ready_d  = 1'b1;
                state_d  = S_END;
            end

            S_END: begin
                if (!div_start) begin
                    ready_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                ready_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // A flush wins over everything and leaves the last result untouched
        if (div_annul) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            ready_d  = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Stall drops in END so the pipeline can advance while the result is valid
    assign div_stall_req = ((state_q == S_IDLE) & div_start & ~div_annul)
                         | (state_q == S_ON)
                         | (state_q == S_BYZERO);

    assign div_result = result_q;
    assign div_ready  = ready_q;

endmodule

// File: doc/ex_div_seq.md
Name: ex_div_seq

Overview:
- Multi-cycle sequencer for the EX-stage divide unit.
- Accepts a DIV/DIVU request from EX and runs a radix-2 restoring division, one quotient bit per cycle.
- Holds the pipeline stall request while the division runs, then presents a {remainder, quotient} result for the HI/LO write path.
- Sits beside the single-cycle EX logic/ALU path. EX selects this block's result when alu_sel indicates a divide.

Parameters:
- WIDTH, 32, operand width; one iteration per bit; result is 2*WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_  in  1  synchronous reset, active-high (1 = reset), sampled on the clk rising edge.
- div_start  in  1  divide request; EX holds it high until div_ready is seen.
- div_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled with div_start.
- div_opdata1  in  WIDTH  dividend.
- div_opdata2  in  WIDTH  divisor.
- div_annul  in  1  abort (pipeline flush); has priority over div_start.
- div_result  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}, registered.
- div_ready  out  1  result valid, registered.
- div_stall_req  out  1  stall request to the pipeline controller, combinational.

Behaviour:
- Reset (rst_=1 at edge): state=IDLE, cnt=0, div_result=0, div_ready=0. Reset overrides every state, including mid-operation.
- States: IDLE, BYZERO, ON, END.
- IDLE
  - div_start=1 and div_annul=0: latch the sign flags and operand magnitudes. Magnitude = two's-complement abs when div_signed=1, raw value otherwise.
  - Divisor==0 -> BYZERO; else -> ON with cnt=0 and partial remainder=0.
  - Otherwise stay in IDLE with div_ready=0.
- ON: each edge performs one iteration.
  - Shift {rem, dvd} left by 1.
  - If rem >= divisor: rem -= divisor and quotient bit = 1; else quotient bit = 0.
  - cnt increments each iteration.
  - On the edge where cnt==WIDTH-1 completes: apply sign correction, write div_result, set div_ready=1, go to END.
  - Latency: start sampled at edge 0; div_ready is high after edge WIDTH (32 for the default).
- Sign correction (signed only):
  - Quotient negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Arithmetic wraps modulo 2^WIDTH, so 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0.
- BYZERO: next edge writes div_result=0, div_ready=1, state END. MIPS leaves this result undefined; this block defines it as zero.
- END
  - div_ready=1 and div_result stay stable while div_start=1.
  - div_start=0 -> IDLE with div_ready=0 on that edge. div_result keeps its value.
  - A new request needs div_start low for at least one edge.
- div_annul=1 in any state except reset: next state IDLE, div_ready=0, cnt=0, no result write. Annul and start together in IDLE leaves the block in IDLE.
- div_stall_req = (IDLE & div_start & ~div_annul) | ON | BYZERO. It is low in END, which lets the pipeline advance while the result is valid.
- Operand inputs may change after the start edge without affecting the result.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, when divisor!=0 and |dividend| < |divisor|, go straight to END.
  - Quotient = 0; remainder = original dividend, sign preserved.
  - div_ready is high after edge 0 (1-cycle latency).
- Undefined: every nonzero-divisor case takes the full WIDTH-cycle path; results are identical either way.

Test Plan:
- Unsigned 100 / 7, div_signed=0
  - div_result = {0x00000002, 0x0000000E}, div_ready high exactly after edge 32.
  - div_stall_req high from edge 0 through edge 31.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002)
  - Quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - Signed 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0.
- Divide by zero, 5 / 0
  - BYZERO then END; div_ready high after edge 1; div_result = 0.
  - Drop start: IDLE and div_ready=0 after the next edge.
- Annul mid-operation
  - Start 100/7, assert div_annul at iteration 10: IDLE next edge, div_ready never rises.
  - A following 9/4 gives q=2, r=1.
- Reset mid-operation
  - rst_=1 at iteration 20: all outputs 0 after that edge.
  - rst_=1 concurrent with div_start: stays in IDLE.
- Early out, 3 / 10
  - With DIV_EARLY_OUT_EN: q=0, r=3, div_ready after edge 0.
  - Without it: same result after edge 32.
